usb_data_buffer: RTL and testbench
==================================

// Module: usb_data_buffer
// PURPOSE
//  Shared packet data FIFO placed directly downstream of the AHB-lite slave register block.
//  The AHB side writes TX bytes with store_tx_data/tx_data and pops RX bytes with get_rx_data/rx_data.
//  The USB side pushes received payload bytes with store_rx_packet_data and pops TX payload bytes with get_tx_packet_data.
//  buffer_occupancy feeds the slave's occupancy register and its DATA-packet gating.
// PARAMETERS
//  DEPTH   64  entries; must be a power of 2
//  ADDR_W  6   pointer width, log2(DEPTH)
//  OCC_W   7   occupancy width, ADDR_W+1 (range 0..DEPTH)
// PORTS
//  clk                   in   1      clock, rising edge
//  n_rst                 in   1      reset, asynchronous, active-low
//  clear                 in   1      AHB flush request; synchronous empty
//  flush                 in   1      USB-side flush (new packet); synchronous empty
//  store_tx_data         in   1      AHB push strobe
//  tx_data               in   8      AHB push byte
//  get_rx_data           in   1      AHB pop strobe
//  rx_data               out  8      head byte, first-word-fall-through
//  store_rx_packet_data  in   1      USB RX push strobe
//  rx_packet_data        in   8      USB RX push byte
//  get_tx_packet_data    in   1      USB TX pop strobe
//  tx_packet_data        out  8      head byte (same source as rx_data)
//  buffer_occupancy      out  OCC_W  number of valid entries
// BEHAVIOUR
//  - Reset: wptr=0, rptr=0, occupancy=0, rx_data=0, tx_packet_data=0. Memory contents are don't-care.
//  - Storage is mem[DEPTH] x 8. Writes land at wptr; the head is mem[rptr]. Pointers wrap modulo DEPTH.
//  - Push: push = store_rx_packet_data | store_tx_data.
//    - If both strobes are high in the same cycle, the RX byte is written and the TX byte is dropped.
//  - Pop: pop = get_rx_data | get_tx_packet_data. Both strobes high in one cycle count as a single pop.
//  - Read data is combinational from registered state:
//    - rx_data = tx_packet_data = mem[rptr] when occupancy > 0, else 8'h00.
//    - The consumer samples the byte in the same cycle it asserts its pop strobe.
//  - Push and pop take effect at the next edge: the pointer advances and the occupancy updates one cycle after the strobe.
//  - Simultaneous push and pop with 0 < occ < DEPTH:
//    - both pointers advance; occupancy is unchanged.
//  - Full (occ == DEPTH):
//    - A push is ignored: wptr, memory and occupancy are unchanged.
//    - Push together with pop: the pop is performed and the push is ignored, so occupancy becomes DEPTH-1.
//  - Empty (occ == 0):
//    - A pop is ignored: rptr is unchanged and the data outputs stay 0.
//    - Push together with pop: the push is performed and the pop is ignored, so occupancy becomes 1.
//  - clear | flush:
//    - Highest priority. At the next edge wptr=rptr=0 and occupancy=0.
//    - Any push or pop in the same cycle is discarded.
//  - n_rst asserted mid-transfer: immediate return to the reset state, with no partial update.
//  - Occupancy is a dedicated OCC_W counter, not pointer subtraction, so a full buffer (64) is distinct from an empty one (0).
// CONFIGURATION
//  - DATA_BUFFER_ERR_FLAGS_EN defined: adds ports overflow_err (out, 1) and underflow_err (out, 1).
//    - Sticky flags, reset 0.
//    - overflow_err sets on the edge after a push that is ignored because the buffer is full.
//    - underflow_err sets on the edge after a pop that is ignored because the buffer is empty.
//    - Both flags clear on clear | flush. Clearing has priority over setting.
//  - DATA_BUFFER_ERR_FLAGS_EN undefined:
//    - Ports and flag logic are absent.
//    - Overflow and underflow are silently ignored as described above.
// TESTING
//  1. Reset, then 4 AHB pushes 8'hA1..8'hA4 -> occupancy 1,2,3,4 on successive cycles.
//     Then 4 get_tx_packet_data pops -> tx_packet_data A1,A2,A3,A4, then 00; occupancy back to 0.
//  2. 64 store_rx_packet_data pushes of 0..63 -> occupancy 64.
//     65th push of 8'hFF -> occupancy stays 64 and the head is still 8'h00; overflow_err=1 when enabled.
//     Then 64 get_rx_data pops -> bytes 0..63 in order.
//  3. Pop while empty -> rx_data=00, occupancy 0, pointers unchanged; underflow_err=1 when enabled.
//  4. With occupancy 10, push and pop in the same cycle for 60 cycles (pointer wrap) -> occupancy stays 10 and data order is preserved.
//  5. With occupancy 20, assert clear in the same cycle as a push -> occupancy 0 next cycle and rx_data=00; error flags cleared.
//     Repeat using flush.
//  6. store_tx_data (8'h55) and store_rx_packet_data (8'hAA) in the same cycle on an empty buffer -> occupancy 1 and head 8'hAA.
//     Assert n_rst mid-stream -> occupancy 0 immediately.

Source files
------------

// File: rtl/usb_data_buffer.sv
// Shared 64-entry packet FIFO between the AHB-lite slave and the USB TX/RX engines.
// Optional sticky overflow/underflow flags are enabled with DATA_BUFFER_ERR_FLAGS_EN.
module usb_data_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int OCC_W  = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             flush,
  input  logic             store_tx_data,
  input  logic [7:0]       tx_data,
  input  logic             get_rx_data,
  output logic [7:0]       rx_data,
  input  logic             store_rx_packet_data,
  input  logic [7:0]       rx_packet_data,
  input  logic             get_tx_packet_data,
  output logic [7:0]       tx_packet_data,
  output logic [OCC_W-1:0] buffer_occupancy
`ifdef DATA_BUFFER_ERR_FLAGS_EN
  ,
  output logic             overflow_err,
  output logic             underflow_err
`endif
);

  localparam logic [OCC_W-1:0]  FULL_OCC = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0]  OCC_ONE  = OCC_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [OCC_W-1:0]  occ;

  logic              flush_all;
  logic              push_req;
  logic              pop_req;
  logic              full;
  logic              empty;
  logic              do_push;
  logic              do_pop;
  logic [7:0]        push_byte;
  logic [7:0]        head;

  assign flush_all = clear | flush;
  assign push_req  = store_rx_packet_data | store_tx_data;
  assign pop_req   = get_rx_data | get_tx_packet_data;
  assign full      = (occ == FULL_OCC);
  assign empty     = (occ == '0);

  // The USB receiver wins a write collision; the AHB byte is dropped.
  assign push_byte = store_rx_packet_data ? rx_packet_data : tx_data;

  assign do_push = push_req & ~full & ~flush_all;
  assign do_pop  = pop_req & ~empty & ~flush_all;

  assign head             = empty ? 8'h00 : mem[rptr];
  assign rx_data          = head;
  assign tx_packet_data   = head;
  assign buffer_occupancy = occ;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= push_byte;
    end
  end

  // A separate occupancy counter keeps full (DEPTH) distinct from empty (0).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else if (flush_all) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (do_pop) begin
        rptr <= rptr + PTR_ONE;
      end
      if (do_push && !do_pop) begin
        occ <= occ + OCC_ONE;
      end else if (do_pop && !do_push) begin
        occ <= occ - OCC_ONE;
      end
    end
  end

`ifdef DATA_BUFFER_ERR_FLAGS_EN
  // Sticky flags; a flush in the same cycle as a rejected access wins.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (flush_all) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (push_req && full) begin
        overflow_err <= 1'b1;
      end
      if (pop_req && empty) begin
        underflow_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_usb_data_buffer.sv
// Self-checking bench for usb_data_buffer: directed table, corner-case sequences and
// randomized traffic compared against a queue-based reference model.
module tb_usb_data_buffer;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       clear;
  logic       flush;
  logic       store_tx_data;
  logic [7:0] tx_data;
  logic       get_rx_data;
  logic [7:0] rx_data;
  logic       store_rx_packet_data;
  logic [7:0] rx_packet_data;
  logic       get_tx_packet_data;
  logic [7:0] tx_packet_data;
  logic [6:0] buffer_occupancy;
`ifdef DATA_BUFFER_ERR_FLAGS_EN
  logic       overflow_err;
  logic       underflow_err;
`endif

  always #5 clk = ~clk;

  usb_data_buffer dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .clear                (clear),
    .flush                (flush),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .get_rx_data          (get_rx_data),
    .rx_data              (rx_data),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .buffer_occupancy     (buffer_occupancy)
`ifdef DATA_BUFFER_ERR_FLAGS_EN
    ,
    .overflow_err         (overflow_err),
    .underflow_err        (underflow_err)
`endif
  );

  typedef struct {
    logic       clr;
    logic       fls;
    logic       st_tx;
    logic [7:0] tx_byte;
    logic       st_rx;
    logic [7:0] rx_byte;
    logic       g_rx;
    logic       g_tx;
    logic [6:0] exp_occ;
    logic [7:0] exp_head;
  } vec_t;

  byte unsigned model_q[$];
  bit           model_ovf;
  bit           model_udf;
  int           n_vec  = 0;
  int           n_miss = 0;

  function automatic logic [7:0] model_head();
    return (model_q.size() > 0) ? model_q[0] : 8'h00;
  endfunction

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] required);
    n_vec++;
    if (actual !== required) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, actual, required, $time);
    end
  endtask

  task automatic check_output(input string tag);
    compare({tag, " occupancy"}, 32'(buffer_occupancy), 32'(model_q.size()));
    compare({tag, " rx_data"}, 32'(rx_data), 32'(model_head()));
    compare({tag, " tx_packet_data"}, 32'(tx_packet_data), 32'(model_head()));
`ifdef DATA_BUFFER_ERR_FLAGS_EN
    compare({tag, " overflow_err"}, 32'(overflow_err), 32'(model_ovf));
    compare({tag, " underflow_err"}, 32'(underflow_err), 32'(model_udf));
`endif
  endtask

  // Reference behaviour: a byte queue with explicit priority rules.
  task automatic model_step(input vec_t v);
    bit was_full, was_empty, push, pop;
    push      = v.st_tx | v.st_rx;
    pop       = v.g_rx | v.g_tx;
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    if (v.clr || v.fls) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_udf = 1'b0;
    end else begin
      if (push && was_full) model_ovf = 1'b1;
      if (pop && was_empty) model_udf = 1'b1;
      if (pop && !was_empty) void'(model_q.pop_front());
      if (push && !was_full) model_q.push_back(v.st_rx ? v.rx_byte : v.tx_byte);
    end
  endtask

  task automatic idle_inputs();
    clear = 0; flush = 0; store_tx_data = 0; tx_data = 0; get_rx_data = 0;
    store_rx_packet_data = 0; rx_packet_data = 0; get_tx_packet_data = 0;
  endtask

  task automatic apply_stimulus(input vec_t v, input string tag);
    @(negedge clk);
    clear = v.clr; flush = v.fls;
    store_tx_data = v.st_tx; tx_data = v.tx_byte;
    store_rx_packet_data = v.st_rx; rx_packet_data = v.rx_byte;
    get_rx_data = v.g_rx; get_tx_packet_data = v.g_tx;
    @(posedge clk);
    #1;
    idle_inputs();
    model_step(v);
    check_output(tag);
  endtask

  function automatic vec_t mk(input logic clr, input logic fls, input logic st_tx, input logic [7:0] txb,
                              input logic st_rx, input logic [7:0] rxb, input logic g_rx, input logic g_tx,
                              input logic [6:0] occ, input logic [7:0] hd);
    vec_t v;
    v.clr = clr; v.fls = fls; v.st_tx = st_tx; v.tx_byte = txb; v.st_rx = st_rx; v.rx_byte = rxb;
    v.g_rx = g_rx; v.g_tx = g_tx; v.exp_occ = occ; v.exp_head = hd;
    return v;
  endfunction

  task automatic push_rx(input logic [7:0] b, input string tag);
    apply_stimulus(mk(0, 0, 0, 8'h00, 1, b, 0, 0, 0, 0), tag);
  endtask

  task automatic pop_rx(input string tag);
    apply_stimulus(mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0), tag);
  endtask

  task automatic fill_to(input int level, input string tag);
    while (model_q.size() < level) push_rx(8'($urandom), tag);
  endtask

  vec_t table_v[$];

  initial begin
    model_ovf = 0;
    model_udf = 0;
    idle_inputs();
    n_rst = 0;
    repeat (2) @(negedge clk);
    check_output("reset");
    @(negedge clk);
    n_rst = 1;

    // Directed table from an empty buffer.
    table_v.push_back(mk(0, 0, 1, 8'hA1, 0, 8'h00, 0, 0, 7'd1, 8'hA1));
    table_v.push_back(mk(0, 0, 1, 8'hA2, 0, 8'h00, 0, 0, 7'd2, 8'hA1));
    table_v.push_back(mk(0, 0, 1, 8'hA3, 0, 8'h00, 0, 0, 7'd3, 8'hA1));
    table_v.push_back(mk(0, 0, 1, 8'hA4, 0, 8'h00, 0, 0, 7'd4, 8'hA1));
    table_v.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 7'd3, 8'hA2));
    table_v.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 7'd2, 8'hA3));
    table_v.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 7'd1, 8'hA4));
    table_v.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 7'd0, 8'h00));
    table_v.push_back(mk(0, 0, 1, 8'h55, 1, 8'hAA, 0, 0, 7'd1, 8'hAA));
    table_v.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 7'd0, 8'h00));
    table_v.push_back(mk(0, 0, 0, 8'h00, 1, 8'h11, 0, 0, 7'd1, 8'h11));
    table_v.push_back(mk(0, 0, 0, 8'h00, 1, 8'h22, 1, 0, 7'd1, 8'h22));
    table_v.push_back(mk(1, 0, 1, 8'h33, 0, 8'h00, 0, 0, 7'd0, 8'h00));
    for (int i = 0; i < table_v.size(); i++) begin
      apply_stimulus(table_v[i], "table");
      compare("table exp_occ", 32'(buffer_occupancy), 32'(table_v[i].exp_occ));
      compare("table exp_head", 32'(tx_packet_data), 32'(table_v[i].exp_head));
    end

    // Fill to full, reject a 65th push, then drain in order.
    for (int i = 0; i < DEPTH; i++) push_rx(8'(i), "fill");
    compare("full occupancy", 32'(buffer_occupancy), 32'd64);
    push_rx(8'hFF, "overflow push");
    compare("overflow occupancy", 32'(buffer_occupancy), 32'd64);
    compare("overflow head", 32'(rx_data), 32'h00);
    for (int i = 0; i < DEPTH; i++) begin
      compare("drain order", 32'(rx_data), 32'(i));
      pop_rx("drain");
    end
    compare("drained occupancy", 32'(buffer_occupancy), 32'd0);

    // Full with push and pop together: pop wins.
    for (int i = 0; i < DEPTH; i++) push_rx(8'(i + 100), "refill");
    apply_stimulus(mk(0, 0, 1, 8'h77, 0, 8'h00, 0, 1, 0, 0), "full push+pop");
    compare("full push+pop occupancy", 32'(buffer_occupancy), 32'd63);
    apply_stimulus(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0), "flush after full");

    // Pop while empty, then confirm the read pointer did not move.
    pop_rx("empty pop");
    apply_stimulus(mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0), "empty double pop");
    compare("empty rx_data", 32'(rx_data), 32'h00);
    apply_stimulus(mk(0, 0, 1, 8'h5A, 0, 8'h00, 1, 0, 0, 0), "empty push+pop");
    compare("empty push+pop occupancy", 32'(buffer_occupancy), 32'd1);
    compare("empty push+pop head", 32'(rx_data), 32'h5A);
    pop_rx("empty cleanup");

    // Steady state at occupancy 10 across pointer wrap.
    fill_to(10, "prefill10");
    for (int i = 0; i < 60; i++) begin
      if (i[0]) apply_stimulus(mk(0, 0, 1, 8'($urandom), 0, 8'h00, 1, 0, 0, 0), "steady tx");
      else      apply_stimulus(mk(0, 0, 0, 8'h00, 1, 8'($urandom), 0, 1, 0, 0), "steady rx");
    end
    compare("steady occupancy", 32'(buffer_occupancy), 32'd10);

    // Clear, then flush, each colliding with a push at occupancy 20.
    fill_to(20, "prefill20");
    apply_stimulus(mk(1, 0, 1, 8'h99, 0, 8'h00, 0, 0, 0, 0), "clear+push");
    compare("clear occupancy", 32'(buffer_occupancy), 32'd0);
    compare("clear rx_data", 32'(rx_data), 32'h00);
    pop_rx("re-underflow");
    fill_to(20, "prefill20b");
    apply_stimulus(mk(0, 1, 0, 8'h00, 1, 8'h98, 1, 0, 0, 0), "flush+push");
    compare("flush occupancy", 32'(buffer_occupancy), 32'd0);
    compare("flush rx_data", 32'(rx_data), 32'h00);

    // Collision on an empty buffer, then an asynchronous reset mid-stream.
    apply_stimulus(mk(0, 0, 1, 8'h55, 1, 8'hAA, 0, 0, 0, 0), "collision");
    compare("collision occupancy", 32'(buffer_occupancy), 32'd1);
    compare("collision head", 32'(rx_data), 32'hAA);
    fill_to(5, "prereset");
    @(negedge clk);
    store_tx_data = 1; tx_data = 8'hEE;
    #2;
    n_rst = 0;
    #1;
    model_q.delete();
    model_ovf = 0;
    model_udf = 0;
    check_output("async reset");
    @(posedge clk);
    #1;
    check_output("held reset");
    idle_inputs();
    @(negedge clk);
    n_rst = 1;

    // Randomized traffic with phases biased towards filling or draining.
    for (int blk = 0; blk < 40; blk++) begin
      int push_pct;
      int pop_pct;
      push_pct = $urandom_range(10, 90);
      pop_pct  = $urandom_range(10, 90);
      for (int i = 0; i < 60; i++) begin
        vec_t v;
        v = mk(($urandom_range(0, 199) == 0), ($urandom_range(0, 199) == 0),
               ($urandom_range(0, 99) < push_pct), 8'($urandom),
               ($urandom_range(0, 99) < push_pct / 2), 8'($urandom),
               ($urandom_range(0, 99) < pop_pct), ($urandom_range(0, 99) < pop_pct / 3), 0, 0);
        apply_stimulus(v, "random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
